// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants, IF/ID widths and state encoding for the fetch stage
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  // IF/ID field widths, shared with the decode stage
  localparam int IF_ID_INSTR_W = 32;
  localparam int IF_ID_PC_W    = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with hold, bubble insert and reset
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [IF_ID_INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_hold,
  input  logic                     i_flush,
  input  logic [IF_ID_INSTR_W-1:0] i_instr,
  input  logic [IF_ID_PC_W-1:0]    i_pc,
  input  logic [IF_ID_PC_W-1:0]    i_pc4,
  output logic [IF_ID_INSTR_W-1:0] o_instr,
  output logic [IF_ID_PC_W-1:0]    o_pc,
  output logic [IF_ID_PC_W-1:0]    o_pc4,
  output logic                     o_valid
);

  logic [IF_ID_INSTR_W-1:0] r_instr;
  logic [IF_ID_PC_W-1:0]    r_pc;
  logic [IF_ID_PC_W-1:0]    r_pc4;
  logic                     r_valid;

  // A bubble only rewrites instr/valid; the PC fields keep their last value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, next-PC selection, RUN/HALT control, IF/ID
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        pc_oor,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LP_DEPTH = 32'(IMEM_DEPTH);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_fetch_count;
  logic         r_misalign;
  logic [31:0]  w_pc4;
  logic [31:0]  w_pc_next;
  logic         w_flush;
  logic         w_hold;
  logic         w_count_inc;
  logic         w_set_misalign;

  assign w_pc4 = r_pc + 32'd4;

  // Priority in RUN: halt > branch > stall > sequential fetch
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_flush        = 1'b0;
    w_hold         = 1'b0;
    w_count_inc    = 1'b0;
    w_set_misalign = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (halt) begin
          w_state_next = ST_HALT;
          w_flush      = 1'b1;
        end else if (branch_taken) begin
          w_pc_next      = {branch_target[31:2], 2'b00};
          w_flush        = 1'b1;
          w_set_misalign = |branch_target[1:0];
        end else if (stall) begin
          w_hold = 1'b1;
        end else begin
          w_pc_next   = w_pc4;
          w_count_inc = 1'b1;
        end
      end
      ST_HALT: begin
        w_flush = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_count_inc) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_set_misalign) r_misalign <= 1'b1;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (w_hold),
    .i_flush (w_flush),
    .i_instr (imem_instr),
    .i_pc    (r_pc),
    .i_pc4   (w_pc4),
    .o_instr (if_id_instr),
    .o_pc    (if_id_pc),
    .o_pc4   (if_id_pc4),
    .o_valid (if_id_valid)
  );

  assign imem_addr    = r_pc;
  assign pc_oor       = (r_pc >> 2) >= LP_DEPTH;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        pc_oor;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] w_addr;
  logic [31:0] w_instr_o;
  logic [31:0] w_pc_o;
  logic [31:0] w_pc4_o;
  logic        w_valid_o;
  logic        w_oor;
  logic        w_mis;
  logic [31:0] w_cnt;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .pc_oor        (pc_oor),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .stall         (1'b0),
    .branch_taken  (1'b0),
    .branch_target (32'h0),
    .halt          (1'b0),
    .imem_addr     (w_addr),
    .imem_instr    (32'h1234_5678),
    .if_id_instr   (w_instr_o),
    .if_id_pc      (w_pc_o),
    .if_id_pc4     (w_pc4_o),
    .if_id_valid   (w_valid_o),
    .pc_oor        (w_oor),
    .misalign_err  (w_mis),
    .fetch_count   (w_cnt)
  );

  // memory word k holds 0x00221820 + 2k
  assign imem_instr = 32'h0022_1820 + {22'd0, imem_addr[9:2], 1'b0};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        halt;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        chk_pc;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
    //        st br tgt   hl addr  instr         chkpc pc  v  cnt mis
    vecs.push_back('{0, 0, 32'h00, 0, 32'h08, 32'h0022_1822, 1, 32'h04, 1, 2, 0});
    vecs.push_back('{1, 0, 32'h00, 0, 32'h08, 32'h0022_1822, 1, 32'h04, 1, 2, 0});
    vecs.push_back('{1, 0, 32'h00, 0, 32'h08, 32'h0022_1822, 1, 32'h04, 1, 2, 0});
    vecs.push_back('{0, 0, 32'h00, 0, 32'h0C, 32'h0022_1824, 1, 32'h08, 1, 3, 0});
    vecs.push_back('{0, 0, 32'h00, 0, 32'h10, 32'h0022_1826, 1, 32'h0C, 1, 4, 0});
    vecs.push_back('{0, 0, 32'h00, 0, 32'h14, 32'h0022_1828, 1, 32'h10, 1, 5, 0});
    vecs.push_back('{0, 0, 32'h00, 0, 32'h18, 32'h0022_182A, 1, 32'h14, 1, 6, 0});
    vecs.push_back('{0, 0, 32'h00, 0, 32'h1C, 32'h0022_182C, 1, 32'h18, 1, 7, 0});
    vecs.push_back('{0, 1, 32'h44, 0, 32'h44, 32'h0000_0000, 0, 32'h00, 0, 7, 0});
    vecs.push_back('{0, 0, 32'h00, 0, 32'h48, 32'h0022_1842, 1, 32'h44, 1, 8, 0});
    vecs.push_back('{1, 1, 32'h46, 0, 32'h44, 32'h0000_0000, 0, 32'h00, 0, 8, 1});
    vecs.push_back('{0, 0, 32'h00, 0, 32'h48, 32'h0022_1842, 1, 32'h44, 1, 9, 1});
    vecs.push_back('{0, 1, 32'h20, 0, 32'h20, 32'h0000_0000, 0, 32'h00, 0, 9, 1});
    vecs.push_back('{0, 1, 32'h80, 1, 32'h20, 32'h0000_0000, 0, 32'h00, 0, 9, 1});
    vecs.push_back('{0, 1, 32'h80, 0, 32'h20, 32'h0000_0000, 0, 32'h00, 0, 9, 1});
    vecs.push_back('{1, 0, 32'h00, 0, 32'h20, 32'h0000_0000, 0, 32'h00, 0, 9, 1});
    vecs.push_back('{0, 0, 32'h00, 0, 32'h20, 32'h0000_0000, 0, 32'h00, 0, 9, 1});

    tick();
    tick();
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc",    if_id_pc, 32'h0);
    chk("rst_pc4",   if_id_pc4, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_cnt",   fetch_count, 32'd0);
    chk("rst_mis",   {31'd0, misalign_err}, 32'd0);
    chk("rst_oor",   {31'd0, pc_oor}, 32'd0);
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_rst_oor",  {31'd0, w_oor}, 32'd1);

    rst = 1'b0;
    tick();
    chk("seq0_addr",  imem_addr, 32'h4);
    chk("seq0_instr", if_id_instr, 32'h0022_1820);
    chk("seq0_pc",    if_id_pc, 32'h0);
    chk("seq0_pc4",   if_id_pc4, 32'h4);
    chk("seq0_valid", {31'd0, if_id_valid}, 32'd1);
    chk("seq0_cnt",   fetch_count, 32'd1);
    chk("wrap_addr",  w_addr, 32'h0);
    chk("wrap_oor",   {31'd0, w_oor}, 32'd0);
    chk("wrap_pc",    w_pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4",   w_pc4_o, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall;
      branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt;
      halt = vecs[i].halt;
      tick();
      chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_instr", i), if_id_instr, vecs[i].instr);
      chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("v%0d_cnt", i),   fetch_count, vecs[i].cnt);
      chk($sformatf("v%0d_mis", i),   {31'd0, misalign_err}, {31'd0, vecs[i].mis});
      if (vecs[i].chk_pc) begin
        chk($sformatf("v%0d_pc", i),  if_id_pc, vecs[i].pc);
        chk($sformatf("v%0d_pc4", i), if_id_pc4, vecs[i].pc + 32'd4);
      end
    end

    stall = 1'b0; branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
    rst = 1'b1;
    tick();
    chk("rerst_addr",  imem_addr, 32'h0);
    chk("rerst_mis",   {31'd0, misalign_err}, 32'd0);
    chk("rerst_cnt",   fetch_count, 32'd0);
    chk("rerst_valid", {31'd0, if_id_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("resume_addr",  imem_addr, 32'h4);
    chk("resume_pc",    if_id_pc, 32'h0);
    chk("resume_valid", {31'd0, if_id_valid}, 32'd1);
    chk("resume_cnt",   fetch_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined DLX/MIPS-style core; the initiator that drives the instruction memory's word-addressed read port (byte address in, 32-bit instruction out, zero-latency combinational read).
- Owns the PC and the IF/ID pipeline register, and applies stall, flush/branch redirect and halt.
- Downstream consumer: the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 256, instruction memory depth in words; used only for the out-of-range flag.
- NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on bubbles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit request; hold PC and IF/ID.
- branch_taken  input  1  redirect request from EX; valid for one cycle.
- branch_target  input  32  redirect byte address.
- halt  input  1  enter HALT state; exit only via rst.
- imem_addr  output  32  byte address to instruction memory (equals PC).
- imem_instr  input  32  instruction returned combinationally for imem_addr.
- if_id_instr  output  32  latched instruction.
- if_id_pc  output  32  PC of the latched instruction.
- if_id_pc4  output  32  if_id_pc + 4.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- pc_oor  output  1  combinational; (PC >> 2) >= IMEM_DEPTH.
- misalign_err  output  1  sticky; set when a redirect target has [1:0] != 0.
- fetch_count  output  32  number of valid instructions delivered to IF/ID.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - PC = RESET_PC, state = RUN.
  - if_id_instr = NOP_INSTR, if_id_pc = 0, if_id_pc4 = 0, if_id_valid = 0.
  - misalign_err = 0, fetch_count = 0.
  - Reset mid-operation discards everything in flight, including a pending branch.
- imem_addr = PC at all times, with no register between them; fetch latency is 1 cycle from PC to IF/ID.
- State machine, two states: RUN, HALT.
  - RUN to HALT: halt = 1 sampled at a clock edge.
  - HALT to RUN: rst only.
  - In HALT: PC holds; IF/ID loads a bubble every cycle; stall and branch_taken are ignored.
- Priority in RUN, per clock edge: rst > halt > branch_taken > stall > normal.
  - Normal: PC <= PC + 4; IF/ID <= {imem_instr, PC, PC+4, valid=1}; fetch_count += 1.
  - branch_taken:
    - PC <= {branch_target[31:2], 2'b00}.
    - IF/ID <= bubble (NOP_INSTR, valid = 0); the wrong-path fetch is squashed.
    - If branch_target[1:0] != 0, set misalign_err.
    - fetch_count holds.
  - stall (no branch): PC and all IF/ID fields hold; fetch_count holds.
  - branch_taken together with stall: the branch wins; the redirect is never lost.
  - halt together with branch_taken: halt wins; PC holds its current value.
- Arithmetic:
  - PC + 4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no error.
  - fetch_count wraps modulo 2^32.
- pc_oor is informational only: the fetch still proceeds, and memory index truncation is the memory's concern.
- PC[1:0] is always 00; only RESET_PC and the masked redirect target can load the PC.

Decomposition:
- Shared package holds:
  - NOP_INSTR and the default RESET_PC.
  - State encoding: RUN = 1'b0, HALT = 1'b1.
  - The IF/ID field widths, which the decode stage reuses.
- One natural sub-module: if_id_reg, the IF/ID register with hold (stall), bubble-insert (flush) and reset controls.
- PC and next-PC logic stay in fetch_unit.

Test Plan:
- Sequential fetch:
  - Stimulus: rst for 2 cycles, then run with memory word0 = 32'h0022_1820, word1 = 32'h0022_1822, word2 = 32'h0022_1824.
  - Response: imem_addr goes 0, 4, 8 on consecutive cycles; if_id_instr/pc go 0x00221820/0, then 0x00221822/4, then 0x00221824/8; valid = 1; fetch_count = 3.
- Stall hold:
  - Stimulus: stall = 1 for 2 cycles while PC = 8.
  - Response: imem_addr stays 8; IF/ID holds pc = 4 and instr 0x00221822; fetch_count is unchanged; fetching resumes at 8 after release.
- Branch redirect:
  - Stimulus: branch_taken = 1, branch_target = 32'h0000_0044, at PC = 0x1C.
  - Response: next cycle imem_addr = 0x44 and if_id_valid = 0 with instr = NOP; the following cycle if_id_pc = 0x44 and valid = 1.
- Branch with stall, and misaligned target:
  - Stimulus: branch_taken = 1, stall = 1, branch_target = 0x46.
  - Response: PC = 0x44; misalign_err = 1 and stays 1 until rst.
- Halt and wrap:
  - Stimulus: halt at PC = 0x20.
  - Response: PC stays 0x20 and bubbles flow indefinitely; a later branch is ignored; rst returns PC to 0.
  - Separately, RESET_PC = 32'hFFFF_FFFC: second fetch address = 0, and pc_oor is 1 then 0.
